// File: rtl/wb_serial_responder.sv
// -----------------------------------------------------------------------------
// wb_serial_responder
//
// Wishbone target with a four-register window (CMD, TX, RX, STATUS) and a
// byte-wide, MSB-first serial shift engine. Every strobed cycle is acked one
// cycle later for exactly one cycle. A CMD write with bit0=1 loads the shifter
// from TX and runs one 8-bit transfer, during which WB_BUSY_O is high. The
// byte clocked in on SER_DI_I lands in RX, and the sticky DONE flag is set.
//
// Ports
//   CLK_IN     : system clock, rising edge
//   RESET_IN   : asynchronous active-high reset
//   WB_ADR_I   : register select (0 CMD, 1 TX, 2 RX, 3 STATUS)
//   WB_DAT_I   : write data
//   WB_DAT_O   : read data, non-zero only while WB_ACK_O=1
//   WB_WE_I    : 1 = write, 0 = read
//   WB_STB_I   : strobe
//   WB_CYC_I   : cycle
//   WB_ACK_O   : single-cycle acknowledge
//   WB_BUSY_O  : serial transfer in progress
//   SER_CLK_O  : serial clock, idles low
//   SER_DO_O   : serial data out, MSB first
//   SER_DI_I   : serial data in, sampled on SER_CLK_O rising
// -----------------------------------------------------------------------------
module wb_serial_responder #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              CLK_IN,
    input  logic              RESET_IN,
    input  logic [1:0]        WB_ADR_I,
    input  logic [DATA_W-1:0] WB_DAT_I,
    output logic [DATA_W-1:0] WB_DAT_O,
    input  logic              WB_WE_I,
    input  logic              WB_STB_I,
    input  logic              WB_CYC_I,
    output logic              WB_ACK_O,
    output logic              WB_BUSY_O,
    output logic              SER_CLK_O,
    output logic              SER_DO_O,
    input  logic              SER_DI_I
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_LOW  = 3'd2,
        ST_HIGH = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic       ack_q, ack_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] shift_q, shift_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       start_q, start_d;
    logic [7:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic       sclk_q, sclk_d;
    logic       sdo_q, sdo_d;

    logic       access;
    logic       engine_busy;
    logic       done_set;
    logic       err_set;
    logic [1:0] status_clr;

    assign WB_ACK_O  = ack_q;
    assign WB_DAT_O  = DATA_W'(rdata_q);
    assign WB_BUSY_O = (state_q != ST_IDLE);
    assign SER_CLK_O = sclk_q;
    assign SER_DO_O  = sdo_q;

    always_comb begin
        state_d    = state_q;
        rdata_d    = '0;
        tx_d       = tx_q;
        rx_d       = rx_q;
        shift_d    = shift_q;
        start_d    = 1'b0;
        div_d      = div_q;
        bit_d      = bit_q;
        sclk_d     = sclk_q;
        sdo_d      = sdo_q;
        done_set   = 1'b0;
        err_set    = 1'b0;
        status_clr = 2'b00;

        // A new access is only recognised when no ack is outstanding, so a
        // held strobe is acked on alternate cycles.
        access  = WB_STB_I & WB_CYC_I & ~ack_q;
        ack_d   = access;

        // start_q covers the ack cycle of a start, before the engine leaves IDLE.
        engine_busy = (state_q != ST_IDLE) | start_q;

        // Read data is taken from the pre-edge register contents.
        if (access && !WB_WE_I) begin
            case (WB_ADR_I)
                2'd0: rdata_d = 8'h00;
                2'd1: rdata_d = tx_q;
                2'd2: rdata_d = rx_q;
                2'd3: rdata_d = {5'b0, WB_BUSY_O, err_q, done_q};
            endcase
        end

        if (access && WB_WE_I) begin
            case (WB_ADR_I)
                2'd0: begin
                    if (WB_DAT_I[0]) begin
                        if (engine_busy) begin
                            err_set = 1'b1;
                        end else begin
                            start_d = 1'b1;
                            shift_d = tx_q;
                        end
                    end
                end
                2'd1: if (!engine_busy) tx_d = WB_DAT_I[7:0];
                2'd3: status_clr = WB_DAT_I[1:0];
                default: ;
            endcase
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    state_d = ST_LOAD;
                    bit_d   = 3'd7;
                    sdo_d   = shift_q[7];
                end
            end
            ST_LOAD: begin
                state_d = ST_LOW;
                div_d   = DIV_RELOAD;
                sclk_d  = 1'b0;
                sdo_d   = shift_q[7];
            end
            ST_LOW: begin
                if (div_q == 8'd0) begin
                    // Rising serial clock: capture the input bit into the LSB.
                    state_d = ST_HIGH;
                    div_d   = DIV_RELOAD;
                    sclk_d  = 1'b1;
                    shift_d = {shift_q[6:0], SER_DI_I};
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            ST_HIGH: begin
                if (div_q == 8'd0) begin
                    sclk_d = 1'b0;
                    if (bit_q == 3'd0) begin
                        state_d  = ST_DONE;
                        sdo_d    = 1'b0;
                        rx_d     = shift_q;
                        done_set = 1'b1;
                    end else begin
                        state_d = ST_LOW;
                        bit_d   = bit_q - 3'd1;
                        div_d   = DIV_RELOAD;
                        sdo_d   = shift_q[7];
                    end
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Setting a sticky flag takes priority over a same-edge clear.
        done_d = (done_q & ~status_clr[0]) | done_set;
        err_d  = (err_q  & ~status_clr[1]) | err_set;
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            rdata_q <= 8'h00;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            shift_q <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            div_q   <= 8'h00;
            bit_q   <= 3'd0;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
        end
    end

endmodule

// File: tb/tb_wb_serial_responder.sv
// -----------------------------------------------------------------------------
// tb_wb_serial_responder
//
// Directed scenarios with literal expectations, followed by randomized bus
// traffic and random serial input. A reference model derives every output
// from the time elapsed since a transfer began and is compared against the DUT
// at every falling clock edge.
// -----------------------------------------------------------------------------
module tb_wb_serial_responder;

    localparam int D     = 4;
    localparam int NPH   = 16 * D;
    localparam int LASTK = NPH + 1;

    logic       clk;
    logic       rst;
    logic [1:0] adr;
    logic [7:0] wdat;
    logic [7:0] dat_o;
    logic       we, stb, cyc;
    logic       ack, busy, ser_clk, ser_do;
    logic       di, di_rand, loop_en, rand_di_en;

    int n_checks;
    int n_fail;

    assign di = loop_en ? ser_do : di_rand;

    wb_serial_responder #(.CLK_DIV(D), .DATA_W(8)) dut (
        .CLK_IN   (clk),
        .RESET_IN (rst),
        .WB_ADR_I (adr),
        .WB_DAT_I (wdat),
        .WB_DAT_O (dat_o),
        .WB_WE_I  (we),
        .WB_STB_I (stb),
        .WB_CYC_I (cyc),
        .WB_ACK_O (ack),
        .WB_BUSY_O(busy),
        .SER_CLK_O(ser_clk),
        .SER_DO_O (ser_do),
        .SER_DI_I (di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic       m_ack;
    logic [7:0] m_dat, m_tx, m_rx, m_acc, m_byte;
    logic       m_done, m_err, m_pend, m_act;
    int         m_k;

    logic       s_acc, s_start, s_err_set, s_done_set, e_clk, e_do;
    logic [7:0] s_dat;
    logic [1:0] s_clr;
    int         s_bidx;

    task automatic m_reset();
        m_ack = 0; m_dat = 0; m_tx = 0; m_rx = 0; m_acc = 0; m_byte = 0;
        m_done = 0; m_err = 0; m_pend = 0; m_act = 0; m_k = 0;
    endtask

    initial begin : scoreboard
        m_reset();
        forever begin
            @(negedge clk);
            if (rst) m_reset();
            // Expected serial outputs from the cycle offset m_k into a transfer:
            // k=0 load, k=1..NPH alternating D-cycle low/high phases, k=NPH+1 done.
            e_clk = m_act && (m_k >= 1) && (m_k <= NPH) && ((((m_k - 1) / D) % 2) == 1);
            if (!m_act || m_k > NPH) begin
                e_do = 1'b0;
            end else if (m_k == 0) begin
                e_do = m_byte[7];
            end else begin
                s_bidx = 7 - (m_k - 1) / (2 * D);
                e_do   = m_byte[s_bidx];
            end
            check("ack",     {31'b0, ack},     {31'b0, m_ack});
            check("dat_o",   {24'b0, dat_o},   {24'b0, m_dat});
            check("busy",    {31'b0, busy},    {31'b0, m_act});
            check("ser_clk", {31'b0, ser_clk}, {31'b0, e_clk});
            check("ser_do",  {31'b0, ser_do},  {31'b0, e_do});

            if (!rst) begin
                s_acc = stb && cyc && !m_ack;
                s_dat = 8'h00; s_start = 0; s_err_set = 0; s_done_set = 0; s_clr = 2'b00;
                if (s_acc && !we) begin
                    if (adr == 2'd1) s_dat = m_tx;
                    else if (adr == 2'd2) s_dat = m_rx;
                    else if (adr == 2'd3) s_dat = {5'b0, m_act, m_err, m_done};
                end
                if (s_acc && we) begin
                    if (adr == 2'd0 && wdat[0]) begin
                        if (m_act || m_pend) s_err_set = 1;
                        else s_start = 1;
                    end else if (adr == 2'd1 && !(m_act || m_pend)) begin
                        m_tx = wdat;
                    end else if (adr == 2'd3) begin
                        s_clr = wdat[1:0];
                    end
                end
                if (m_act) begin
                    // The last low cycle of each bit precedes the capture edge.
                    if (m_k >= 1 && m_k <= NPH && ((m_k - 1) % (2 * D)) == D - 1)
                        m_acc = {m_acc[6:0], di};
                    if (m_k == NPH) begin
                        m_rx = m_acc;
                        s_done_set = 1;
                    end
                end
                if (m_pend) begin
                    m_act = 1; m_k = 0; m_pend = 0; m_acc = 0;
                end else if (m_act) begin
                    if (m_k == LASTK) m_act = 0;
                    else m_k++;
                end
                if (s_start) begin
                    m_pend = 1;
                    m_byte = m_tx;
                end
                m_done = (m_done && !s_clr[0]) || s_done_set;
                m_err  = (m_err  && !s_clr[1]) || s_err_set;
                m_dat  = s_dat;
                m_ack  = s_acc;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus(input logic [1:0] a, input logic w, input logic [7:0] d,
                       output logic [7:0] rdat, output int lat);
        bit got;
        got  = 0;
        rdat = 8'h00;
        lat  = -1;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = a; wdat = d;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (ack) begin
                got  = 1;
                rdat = dat_o;
                lat  = i;
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL bus_ack_timeout: adr=%0d we=%0b got no ack, expected one", a, w);
        end
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] r;
        int l;
        bus(a, 1'b1, d, r, l);
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] r;
        int l;
        bus(a, 1'b0, 8'h00, r, l);
        check(name, {24'b0, r}, {24'b0, exp});
        $display("read  %-12s adr=%0d data=0x%02h", name, a, r);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 3000 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1;
        end
        check("wait_idle", {31'b0, idle}, 32'd1);
    endtask

    // Follows a transfer that has just been started, from the first busy cycle.
    task automatic monitor(output int busy_cyc, output int pulses,
                           output logic [7:0] do_bits, output int bad_hi);
        logic prev;
        int   hi;
        bit   fin;
        busy_cyc = 0; pulses = 0; do_bits = 0; bad_hi = 0;
        prev = 0; hi = 0; fin = 0;
        for (int i = 0; i < 3000 && !fin; i++) begin
            @(negedge clk);
            if (!busy) begin
                fin = 1;
            end else begin
                busy_cyc++;
                if (ser_clk && !prev) begin
                    pulses++;
                    do_bits = {do_bits[6:0], ser_do};
                end
                if (ser_clk) hi++;
                else if (prev) begin
                    if (hi != D) bad_hi++;
                    hi = 0;
                end
                prev = ser_clk;
            end
        end
    endtask

    // Random serial input, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_di_en) di_rand = 1'($urandom);
        end
    end

    // ---------------- directed + random sequence ----------------
    initial begin : stimulus
        logic [7:0] r, bits;
        int lat, bc, pc, bh, falls, hold, gap;
        logic prevc;

        n_checks = 0; n_fail = 0;
        rst = 1; adr = 0; wdat = 0; we = 0; stb = 0; cyc = 0;
        di_rand = 0; loop_en = 0; rand_di_en = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Reset in the middle of a bus cycle.
        wr(2'd1, 8'h77);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = 2'd1; wdat = 8'h12;
        @(posedge clk); #1;
        rst = 1; cyc = 0; stb = 0; we = 0;
        #1;
        check("rst_ack",  {31'b0, ack},     32'd0);
        check("rst_busy", {31'b0, busy},    32'd0);
        check("rst_sclk", {31'b0, ser_clk}, 32'd0);
        check("rst_dat",  {24'b0, dat_o},   32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        rd_check("rst_status", 2'd3, 8'h00);
        rd_check("rst_tx",     2'd1, 8'h00);

        // Register access.
        wr(2'd1, 8'hA5);
        bus(2'd1, 1'b0, 8'h00, r, lat);
        check("tx_read", {24'b0, r}, 32'hA5);
        check("ack_latency", lat, 1);
        rd_check("cmd_read", 2'd0, 8'h00);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = 2'd1;
        bits = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bits = {bits[6:0], ack};
        end
        @(posedge clk); #1;
        cyc = 0; stb = 0;
        check("held_stb_ack_pattern", {28'b0, bits[3:0]}, 32'h5);

        // Loopback transfer.
        loop_en = 1;
        wr(2'd1, 8'h3C);
        wr(2'd0, 8'h01);
        monitor(bc, pc, bits, bh);
        check("loop_busy_cycles", bc, 66);
        check("loop_pulses", pc, 8);
        check("loop_do_bits", {24'b0, bits}, 32'h3C);
        check("loop_pulse_width_errors", bh, 0);
        $display("xfer  loopback busy=%0d pulses=%0d do=0x%02h", bc, pc, bits);
        rd_check("loop_rx",     2'd2, 8'h3C);
        rd_check("loop_status", 2'd3, 8'h01);

        // Constant-one serial input.
        loop_en = 0; di_rand = 1;
        wr(2'd1, 8'h00);
        wr(2'd0, 8'h01);
        wait_idle();
        rd_check("ones_rx",     2'd2, 8'hFF);
        rd_check("ones_status", 2'd3, 8'h01);
        wr(2'd3, 8'h01);
        rd_check("clr_status",  2'd3, 8'h00);

        // Overrun: start and TX write while busy.
        loop_en = 1;
        wr(2'd1, 8'h5A);
        wr(2'd0, 8'h01);
        repeat (5) @(posedge clk);
        wr(2'd0, 8'h01);
        wr(2'd1, 8'h11);
        wait_idle();
        rd_check("ovr_rx",     2'd2, 8'h5A);
        rd_check("ovr_status", 2'd3, 8'h03);
        rd_check("ovr_tx",     2'd1, 8'h5A);
        wr(2'd3, 8'h03);

        // Reset after the third serial clock pulse.
        wr(2'd1, 8'hC3);
        wr(2'd0, 8'h01);
        falls = 0; prevc = 0;
        for (int i = 0; i < 3000 && falls < 3; i++) begin
            @(negedge clk);
            if (prevc && !ser_clk) falls++;
            prevc = ser_clk;
        end
        check("mid_pulses_seen", falls, 3);
        @(posedge clk); #1 rst = 1;
        #1;
        check("mid_rst_busy", {31'b0, busy},    32'd0);
        check("mid_rst_sclk", {31'b0, ser_clk}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        rd_check("mid_rst_rx", 2'd2, 8'h00);
        wr(2'd1, 8'h96);
        wr(2'd0, 8'h01);
        monitor(bc, pc, bits, bh);
        check("restart_busy_cycles", bc, 66);
        check("restart_pulses", pc, 8);
        $display("xfer  restart busy=%0d pulses=%0d do=0x%02h", bc, pc, bits);
        rd_check("restart_rx", 2'd2, 8'h96);

        // Randomized traffic with random serial input.
        loop_en = 0; rand_di_en = 1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            cyc  = ($urandom_range(0, 7) != 0);
            stb  = ($urandom_range(0, 3) != 0);
            we   = 1'($urandom);
            adr  = 2'($urandom);
            wdat = 8'($urandom);
            if (adr == 2'd0 && $urandom_range(0, 1) == 1) wdat[0] = 1'b1;
            hold = $urandom_range(1, 3);
            gap  = $urandom_range(0, 6);
            $display("rand  op=%0d cyc=%0b stb=%0b we=%0b adr=%0d dat=0x%02h hold=%0d",
                     i, cyc, stb, we, adr, wdat, hold);
            repeat (hold - 1) @(posedge clk);
            if (gap > 0) begin
                @(posedge clk); #1;
                stb = 0; cyc = 0;
                repeat (gap - 1) @(posedge clk);
            end
            if (i == 200) begin
                @(posedge clk); #1 rst = 1;
                repeat (2) @(posedge clk);
                #1 rst = 0;
            end
        end
        @(posedge clk); #1;
        stb = 0; cyc = 0; we = 0;
        wait_idle();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
